// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg
// Shared CPU types: memory-arbiter state encoding, data word, and default
// RAM timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INSTR  = 2'd1,
    DATA   = 2'd2,
    HALTED = 2'd3
  } arb_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// mem_timeout_ctr
// Loadable down-counter. It pulses expired on the TIMEOUT-th enabled cycle
// after load.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_timeout_ctr
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_start = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Loading TIMEOUT-1 makes the count reach zero on the TIMEOUT-th busy cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_start;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = en & ~load & (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// Arbitrates instruction and data requests onto one variable-latency RAM
// port and returns one-cycle hit pulses. Optional hit counters are enabled
// by the MEM_ARB_STATS_EN macro.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  input  logic              halt,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              mem_err
`ifdef MEM_ARB_STATS_EN
  ,
  output word_t             icount,
  output word_t             dcount
`endif
);

  arb_state_t r_state;
  logic       r_ifirst;
  logic       r_halt_pend;
  logic       w_ireq;
  logic       w_dreq;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_busy;
  logic       w_expired;
  logic       w_halting;

  // A requestor still sees its level high during its own hit cycle, so it
  // is masked there to avoid re-granting the completed access.
  always_comb begin
    w_ireq    = iREN & ~ihit;
    w_dreq    = (dREN | dWEN) & ~dhit;
    w_halting = halt | r_halt_pend;
    w_busy    = (r_state == INSTR) || (r_state == DATA);
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if ((r_state == IDLE) && !w_halting) begin
      if (w_dreq && !r_ifirst) begin
        w_grant_d = 1'b1;
      end else if (w_ireq) begin
        w_grant_i = 1'b1;
      end else if (w_dreq) begin
        w_grant_d = 1'b1;
      end
    end
  end

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .load    (w_grant_i | w_grant_d),
    .en      (w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ifirst    <= 1'b0;
      r_halt_pend <= 1'b0;
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      iload       <= '0;
      dload       <= '0;
      ram_ren     <= 1'b0;
      ram_wen     <= 1'b0;
      ram_addr    <= '0;
      ram_store   <= '0;
      mem_err     <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      if (halt) begin
        r_halt_pend <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_halting) begin
            r_state <= HALTED;
          end else if (w_grant_d) begin
            ram_addr  <= daddr;
            ram_store <= dstore;
            ram_wen   <= dWEN;
            ram_ren   <= ~dWEN;
            r_state   <= DATA;
          end else if (w_grant_i) begin
            ram_addr <= iaddr;
            ram_ren  <= 1'b1;
            r_state  <= INSTR;
          end
        end
        INSTR: begin
          if (ram_ready) begin
            iload    <= ram_load;
            ihit     <= iREN;
            r_ifirst <= 1'b0;
            ram_ren  <= 1'b0;
            r_state  <= w_halting ? HALTED : IDLE;
          end else if (w_expired) begin
            ram_ren <= 1'b0;
            mem_err <= 1'b1;
            r_state <= w_halting ? HALTED : IDLE;
          end
        end
        DATA: begin
          if (ram_ready) begin
            if (!ram_wen) begin
              dload <= ram_load;
            end
            dhit     <= dREN | dWEN;
            r_ifirst <= 1'b1;
            ram_ren  <= 1'b0;
            ram_wen  <= 1'b0;
            r_state  <= w_halting ? HALTED : IDLE;
          end else if (w_expired) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            mem_err <= 1'b1;
            r_state <= w_halting ? HALTED : IDLE;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Counters saturate instead of wrapping so a long run never reads low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (ihit && (icount != '1)) begin
        icount <= icount + 1'b1;
      end
      if (dhit && (dcount != '1)) begin
        dcount <= dcount + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the datapath memory-request interface. Serves the instruction-fetch request (iREN/iaddr) and the data requests (dREN/dWEN/daddr/dstore) produced by decode.
- Arbitrates both requestors onto a single RAM port with variable latency and returns one-cycle hit pulses with the load data.
- Sits between the datapath and the RAM or cache.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- TIMEOUT, 255, maximum cycles spent waiting for ram_ready before aborting.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iREN  in  1  instruction read request, level; held until ihit.
- iaddr  in  ADDR_W  instruction address.
- ihit  out  1  one-cycle pulse: iload is valid.
- iload  out  DATA_W  fetched instruction, registered.
- dREN  in  1  data read request, level.
- dWEN  in  1  data write request, level.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  one-cycle pulse: data access complete.
- dload  out  DATA_W  read data, registered.
- halt  in  1  halt request from the pipeline.
- ram_ren  out  1  RAM read strobe, level for the whole access.
- ram_wen  out  1  RAM write strobe, level for the whole access.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data, valid when ram_ready=1.
- ram_ready  in  1  RAM access complete.
- mem_err  out  1  sticky timeout error flag.

Behaviour:
- Clock and reset: one clock CLK; RST is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; fairness bit ifirst=0.
- States:
  - IDLE: sample requests. Grant DATA if (dREN|dWEN) and not ifirst; else grant INSTR if iREN; else grant DATA if (dREN|dWEN).
  - On grant: latch address, store data and op into registers; ram_* outputs assert from the next cycle.
  - DATA and INSTR: hold ram_* stable until ram_ready=1. That cycle captures ram_load into dload or iload. The next cycle pulses dhit or ihit exactly once, and the state returns to IDLE.
- Latency: request seen in IDLE at cycle 0; ram strobe at cycle 1; ram_ready at cycle k≥1; hit at cycle k+1. At least one IDLE cycle separates transactions.
- Fairness: completing a DATA transaction sets ifirst=1; completing an INSTR transaction clears it. With both requests continuously pending, service alternates D,I,D,I.
- dREN and dWEN both high: treated as a write.
- Dropped request: if the requestor deasserts before completion, the RAM access still finishes and the hit is suppressed.
- Writes: dload is unchanged.
- Timeout: a cycle counter (width clog2(TIMEOUT+1)) resets on grant. When it reaches TIMEOUT without ram_ready:
  - drop strobes;
  - set mem_err, which stays set until RST;
  - return to IDLE;
  - issue no hit.
- halt: an in-flight transaction completes normally, then the FSM enters HALTED. HALTED drives no strobes, ignores all requests and is left only by RST.
- RST mid-transaction: strobes drop immediately and asynchronously; no hit is issued.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds outputs icount and dcount (32 bits each, reset 0). They increment on every issued ihit and dhit respectively and saturate at all-ones.
- Undefined: neither port nor counter logic exists.

Decomposition:
- cpu_types_pkg gains:
  - arb_state_t enum {IDLE, INSTR, DATA, HALTED};
  - word_t;
  - MEM_TIMEOUT_DEFAULT constant.
- One natural sub-module, mem_timeout_ctr: a loadable down-counter with an expiry pulse.

Test Plan:
- iREN=1, iaddr=0x40, ram_ready 3 cycles after strobe, ram_load=0x3C010001 -> ram_ren cycle 1, ihit at cycle 5 for one cycle, iload=0x3C010001.
- iREN and dREN both held, daddr=0x100, ram_ready zero-wait -> first grant DATA (ram_addr=0x100), then INSTR; the next grants alternate.
- dWEN=1, daddr=0x80, dstore=0xDEADBEEF -> ram_wen=1, ram_store=0xDEADBEEF; dhit pulses; dload stays 0.
- ram_ready held 0, TIMEOUT=8 -> strobe drops after 8 cycles; mem_err=1 and stays 1; no hit.
- halt asserted during a data access -> dhit is still issued, then HALTED; a subsequent iREN produces no ram_ren.
- RST pulsed while ram_ren=1 -> ram_ren, ihit and dhit go 0 immediately; after release the FSM is in IDLE with mem_err=0.
